// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255 PPI host bus master: op codes, port addresses,
// FSM encoding and control-word encoders.
package ppi_pkg;

   typedef enum logic [1:0] {
      OP_WR_PORT  = 2'd0,
      OP_RD_PORT  = 2'd1,
      OP_MODE_SET = 2'd2,
      OP_BSR      = 2'd3
   } op_e;

   localparam logic [1:0] PORT_A = 2'b00;
   localparam logic [1:0] PORT_B = 2'b01;
   localparam logic [1:0] PORT_C = 2'b10;
   localparam logic [1:0] CTRL   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_RECOV  = 3'd4,
      ST_REJECT = 3'd5
   } state_e;

   // Mode-set words always carry the mode flag in D7.
   function automatic logic [7:0] mode_word(input logic [6:0] bits);
      return {1'b1, bits};
   endfunction

   // BSR words keep D7=0; D3..D1 select the port C bit, D0 is set/clear.
   function automatic logic [7:0] bsr_word(input logic [3:0] bits);
      return {4'b0000, bits[3:1], bits[0]};
   endfunction

endpackage

// File: rtl/ppi_cycle_timer.sv
// Loadable 4-bit down-counter with a zero flag; times every phase of a PPI bus cycle.
module ppi_cycle_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] cnt_q;
   logic [3:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/ppi_host_bus_master.sv
// Host-side initiator for the 8255 PPI: turns single-cycle commands into timed,
// fully registered CS_n/RD_n/WR_n/A/D bus cycles, one transaction at a time.
module ppi_host_bus_master
   import ppi_pkg::*;
#(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1,
   parameter int RECOV_CYC  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       cs_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic [1:0] a,
   output logic [7:0] d_out,
   output logic       d_oe,
   input  logic [7:0] d_in
);

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
   localparam logic [3:0] RECOV_LD  = 4'(RECOV_CYC - 1);

   state_e     state_q, state_d;
   logic       rd_q, rd_d;
   logic [7:0] cap_q, cap_d;
   logic       cmd_ready_q, cmd_ready_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_err_q, rsp_err_d;
   logic       cs_n_q, cs_n_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic [1:0] a_q, a_d;
   logic [7:0] d_out_q, d_out_d;
   logic       d_oe_q, d_oe_d;

   logic       tmr_load, tmr_dec, tmr_zero;
   logic [3:0] tmr_val;

   op_e        op_in;
   logic       port_op, bad_addr;
   logic [7:0] word;
   logic [1:0] addr_eff;

   ppi_cycle_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   // Command decode: what would go onto the bus if this command were accepted now.
   always_comb begin
      op_in    = op_e'(cmd_op);
      port_op  = (op_in == OP_WR_PORT) || (op_in == OP_RD_PORT);
      bad_addr = port_op && (cmd_addr == CTRL);
      addr_eff = port_op ? cmd_addr : CTRL;
      case (op_in)
         OP_MODE_SET: word = mode_word(cmd_data[6:0]);
         OP_BSR:      word = bsr_word(cmd_data[3:0]);
         OP_WR_PORT:  word = cmd_data;
         default:     word = 8'h00;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      cap_d       = cap_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_data_d  = rsp_data_q;
      cs_n_d      = cs_n_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      a_d         = a_q;
      d_out_d     = d_out_q;
      d_oe_d      = d_oe_q;
      tmr_load    = 1'b0;
      tmr_val     = 4'd0;
      tmr_dec     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               if (bad_addr) begin
                  state_d     = ST_REJECT;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = 8'h00;
               end else begin
                  state_d  = ST_SETUP;
                  rd_d     = (op_in == OP_RD_PORT);
                  cs_n_d   = 1'b0;
                  a_d      = addr_eff;
                  d_out_d  = word;
                  d_oe_d   = (op_in != OP_RD_PORT);
                  tmr_load = 1'b1;
                  tmr_val  = SETUP_LD;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               state_d  = ST_STROBE;
               rd_n_d   = !rd_q;
               wr_n_d   = rd_q;
               tmr_load = 1'b1;
               tmr_val  = STROBE_LD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_STROBE: begin
            if (tmr_zero) begin
               state_d  = ST_HOLD;
               rd_n_d   = 1'b1;
               wr_n_d   = 1'b1;
               // This edge still sees rd_n low, so the PPI is driving valid data.
               if (rd_q) begin
                  cap_d = d_in;
               end
               tmr_load = 1'b1;
               tmr_val  = HOLD_LD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = rd_q ? cap_q : 8'h00;
               cs_n_d      = 1'b1;
               d_oe_d      = 1'b0;
               if (RECOV_CYC == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d  = ST_RECOV;
                  tmr_load = 1'b1;
                  tmr_val  = RECOV_LD;
               end
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_RECOV: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rd_q        <= 1'b0;
         cap_q       <= 8'h00;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         a_q         <= 2'b00;
         d_out_q     <= 8'h00;
         d_oe_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         cap_q       <= cap_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         a_q         <= a_d;
         d_out_q     <= d_out_d;
         d_oe_q      <= d_oe_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign cs_n      = cs_n_q;
   assign rd_n      = rd_n_q;
   assign wr_n      = wr_n_q;
   assign a         = a_q;
   assign d_out     = d_out_q;
   assign d_oe      = d_oe_q;

endmodule

// File: tb/tb_ppi_host_bus_master.sv
// Directed self-checking bench for ppi_host_bus_master with default timing parameters.
module tb_ppi_host_bus_master;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_op = 2'd0;
   logic [1:0] cmd_addr = 2'd0;
   logic [7:0] cmd_data = 8'h00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       cs_n, rd_n, wr_n, d_oe;
   logic [1:0] a;
   logic [7:0] d_out;
   logic [7:0] d_in;

   int checks = 0;
   int failures = 0;

   // PPI model: data only present while the read strobe is active.
   assign d_in = rd_n ? 8'h00 : 8'hA5;

   always #5 clk = !clk;

   ppi_host_bus_master dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .cs_n      (cs_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .a         (a),
      .d_out     (d_out),
      .d_oe      (d_oe),
      .d_in      (d_in)
   );

   // Observations from the most recent run_cmd
   int         r_lat, r_wr_lo, r_rd_lo, r_cs_lo;
   logic       r_done, r_both_lo, r_oe_in_rd;
   logic [1:0] r_a;
   logic [7:0] r_d, r_rspd;
   logic       r_err;

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data);
      int n;
      r_lat = 0; r_wr_lo = 0; r_rd_lo = 0; r_cs_lo = 0;
      r_done = 1'b0; r_both_lo = 1'b0; r_oe_in_rd = 1'b0;
      r_a = 2'b00; r_d = 8'h00; r_rspd = 8'h00; r_err = 1'b0;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!cmd_ready) return;
      cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      r_lat = 1;
      for (int i = 0; i < 40; i++) begin
         if (!cs_n) begin r_cs_lo++; r_a = a; end
         if (!wr_n) begin r_wr_lo++; r_d = d_out; end
         if (!rd_n) r_rd_lo++;
         if (!rd_n && !wr_n) r_both_lo = 1'b1;
         if (d_oe && (op == 2'd1 || !rd_n)) r_oe_in_rd = 1'b1;
         if (rsp_valid) begin
            r_done = 1'b1; r_rspd = rsp_data; r_err = rsp_err;
            break;
         end
         @(posedge clk); #1;
         r_lat++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({cs_n, rd_n, wr_n, d_oe, a, d_out} !== {1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 8'h00}) begin
         failures++;
         $display("FAIL reset_bus: got cs_n=%b rd_n=%b wr_n=%b d_oe=%b a=%0d d_out=%h, want 1 1 1 0 0 00",
                  cs_n, rd_n, wr_n, d_oe, a, d_out);
      end
      checks++;
      if ({cmd_ready, rsp_valid, rsp_err, rsp_data} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
         failures++;
         $display("FAIL reset_host: got ready=%b rsp_valid=%b rsp_err=%b rsp_data=%h, want 0 0 0 00",
                  cmd_ready, rsp_valid, rsp_err, rsp_data);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got cmd_ready=%b want 1", cmd_ready);
      end
      $display("reset: ready=%b cs_n=%b", cmd_ready, cs_n);
   endtask

   task automatic test_mode_set();
      run_cmd(2'd2, 2'd0, 8'h1B);
      $display("mode_set 1B: lat=%0d a=%0d d=%h wr_lo=%0d cs_lo=%0d", r_lat, r_a, r_d, r_wr_lo, r_cs_lo);
      checks++;
      if (!r_done || r_lat != 7) begin
         failures++;
         $display("FAIL mode_latency: got done=%b lat=%0d want done=1 lat=7", r_done, r_lat);
      end
      checks++;
      if (r_a !== 2'd3 || r_d !== 8'h9B) begin
         failures++;
         $display("FAIL mode_word: got a=%0d d=%h want a=3 d=9b", r_a, r_d);
      end
      checks++;
      if (r_wr_lo != 3 || r_cs_lo != 6 || r_rd_lo != 0) begin
         failures++;
         $display("FAIL mode_timing: got wr_lo=%0d cs_lo=%0d rd_lo=%0d want 3 6 0", r_wr_lo, r_cs_lo, r_rd_lo);
      end
      checks++;
      if (r_err !== 1'b0 || r_rspd !== 8'h00) begin
         failures++;
         $display("FAIL mode_rsp: got err=%b data=%h want 0 00", r_err, r_rspd);
      end
   endtask

   task automatic test_bsr();
      run_cmd(2'd3, 2'd0, 8'h0B);
      $display("bsr set bit5: a=%0d d=%h", r_a, r_d);
      checks++;
      if (!r_done || r_a !== 2'd3 || r_d !== 8'h0B) begin
         failures++;
         $display("FAIL bsr_set: got done=%b a=%0d d=%h want 1 3 0b", r_done, r_a, r_d);
      end
      run_cmd(2'd3, 2'd1, 8'hF0);
      $display("bsr clr bit0 (upper bits ignored): a=%0d d=%h wr_lo=%0d", r_a, r_d, r_wr_lo);
      checks++;
      if (!r_done || r_a !== 2'd3 || r_d !== 8'h00 || r_wr_lo != 3) begin
         failures++;
         $display("FAIL bsr_clr: got done=%b a=%0d d=%h wr_lo=%0d want 1 3 00 3", r_done, r_a, r_d, r_wr_lo);
      end
   endtask

   task automatic test_rd_port();
      run_cmd(2'd1, 2'd1, 8'h00);
      $display("rd_port B: lat=%0d a=%0d rsp=%h rd_lo=%0d wr_lo=%0d", r_lat, r_a, r_rspd, r_rd_lo, r_wr_lo);
      checks++;
      if (!r_done || r_rspd !== 8'hA5 || r_lat != 7) begin
         failures++;
         $display("FAIL rd_data: got done=%b data=%h lat=%0d want 1 a5 7", r_done, r_rspd, r_lat);
      end
      checks++;
      if (r_a !== 2'd1 || r_rd_lo != 3 || r_wr_lo != 0 || r_oe_in_rd || r_both_lo) begin
         failures++;
         $display("FAIL rd_bus: got a=%0d rd_lo=%0d wr_lo=%0d oe=%b both=%b want 1 3 0 0 0",
                  r_a, r_rd_lo, r_wr_lo, r_oe_in_rd, r_both_lo);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (rsp_data !== 8'hA5) begin
         failures++;
         $display("FAIL rd_hold: got rsp_data=%h want a5", rsp_data);
      end
   endtask

   task automatic test_wr_port();
      run_cmd(2'd0, 2'd2, 8'h5A);
      $display("wr_port C: a=%0d d=%h rsp=%h", r_a, r_d, r_rspd);
      checks++;
      if (!r_done || r_a !== 2'd2 || r_d !== 8'h5A || r_rspd !== 8'h00 || r_wr_lo != 3) begin
         failures++;
         $display("FAIL wr_port: got done=%b a=%0d d=%h rsp=%h wr_lo=%0d want 1 2 5a 00 3",
                  r_done, r_a, r_d, r_rspd, r_wr_lo);
      end
   endtask

   task automatic test_reject();
      run_cmd(2'd0, 2'd3, 8'h77);
      $display("reject wr addr3: lat=%0d err=%b cs_lo=%0d", r_lat, r_err, r_cs_lo);
      checks++;
      if (!r_done || r_lat != 1 || r_err !== 1'b1 || r_cs_lo != 0) begin
         failures++;
         $display("FAIL reject: got done=%b lat=%0d err=%b cs_lo=%0d want 1 1 1 0", r_done, r_lat, r_err, r_cs_lo);
      end
      run_cmd(2'd1, 2'd3, 8'h00);
      $display("reject rd addr3: lat=%0d err=%b data=%h", r_lat, r_err, r_rspd);
      checks++;
      if (!r_done || r_lat != 1 || r_err !== 1'b1 || r_rspd !== 8'h00 || r_cs_lo != 0) begin
         failures++;
         $display("FAIL reject_rd: got done=%b lat=%0d err=%b data=%h cs_lo=%0d want 1 1 1 00 0",
                  r_done, r_lat, r_err, r_rspd, r_cs_lo);
      end
   endtask

   task automatic test_back_to_back();
      logic prev_ready, prev_cs;
      int   acc, rel, acc2, nrsp, n;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 2'd0; cmd_data = 8'h11;
      prev_ready = cmd_ready; prev_cs = cs_n;
      acc = 0; rel = -1; acc2 = -1; nrsp = 0;
      for (int idx = 1; idx < 60 && nrsp < 2; idx++) begin
         @(posedge clk); #1;
         if (prev_ready && cmd_valid) begin
            acc++;
            if (acc == 2) begin
               acc2 = idx;
               cmd_valid = 1'b0;
            end
         end
         if (!prev_cs && cs_n && rel < 0) rel = idx;
         if (rsp_valid) nrsp++;
         prev_ready = cmd_ready; prev_cs = cs_n;
      end
      cmd_valid = 1'b0;
      $display("back_to_back: accepts=%0d rsp=%0d release_at=%0d accept2_at=%0d", acc, nrsp, rel, acc2);
      checks++;
      if (acc != 2 || nrsp != 2 || rel < 0 || acc2 - rel < 2) begin
         failures++;
         $display("FAIL back_to_back: got accepts=%0d rsps=%0d gap=%0d want 2 2 gap>=2", acc, nrsp, acc2 - rel);
      end
   endtask

   task automatic test_reset_mid_cycle();
      int n, stray;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 2'd0; cmd_data = 8'h3C;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      n = 0;
      while (wr_n && n < 20) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (wr_n !== 1'b0) begin
         failures++;
         $display("FAIL mid_reach_strobe: got wr_n=%b want 0", wr_n);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({cs_n, rd_n, wr_n, d_oe, rsp_valid, cmd_ready} !== 6'b111000) begin
         failures++;
         $display("FAIL mid_reset: got cs_n=%b rd_n=%b wr_n=%b d_oe=%b rsp_valid=%b ready=%b want 1 1 1 0 0 0",
                  cs_n, rd_n, wr_n, d_oe, rsp_valid, cmd_ready);
      end
      reset = 1'b0;
      stray = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (rsp_valid) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("FAIL mid_no_rsp: got %0d rsp_valid pulses want 0", stray);
      end
      run_cmd(2'd2, 2'd0, 8'h05);
      $display("after mid reset mode_set 05: lat=%0d d=%h", r_lat, r_d);
      checks++;
      if (!r_done || r_lat != 7 || r_d !== 8'h85 || r_a !== 2'd3) begin
         failures++;
         $display("FAIL mid_recover: got done=%b lat=%0d d=%h a=%0d want 1 7 85 3", r_done, r_lat, r_d, r_a);
      end
   endtask

   initial begin
      test_reset();
      test_mode_set();
      test_bsr();
      test_rd_port();
      test_wr_port();
      test_reject();
      test_back_to_back();
      test_reset_mid_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
